debounce_bank: RTL

Parametrised multi-channel input conditioner for the stopwatch front panel. Each channel synchronises a raw pushbutton or switch, debounces it against a shared sample tick, and produces a clean level, one-cycle rise and fall pulses, and a one-shot long-press pulse. It sits between the board pins and the stopwatch control FSM, replacing one single-channel debouncer per input.

---
 rtl/debounce_bank.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel pushbutton/switch conditioner.
// Each channel is synchronised, debounced against a shared sample tick, and
// produces a clean level plus registered rise, fall and long-press pulses.
module debounce_bank #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned DB_TICKS   = 8,
  parameter int unsigned HOLD_TICKS = 500,
  parameter bit          INVERT     = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CHANNELS-1:0] sig_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic [CHANNELS-1:0] hold_o
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DbW  = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;

  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
  localparam logic [DbW-1:0]  DbMax  = DbW'(DB_TICKS - 1);

  logic [CHANNELS-1:0] s1_q, s2_q;
  logic [PreW-1:0]     pre_q, pre_d;
  logic                tick;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] hold_q, hold_d;
  logic [CHANNELS-1:0] flip;

  // Two-flop synchroniser; runs independently of en so the sampled value is
  // always current when counting resumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sig_i ^ {CHANNELS{INVERT}};
      s2_q <= s1_q;
    end
  end

  // Prescaler next state and shared sample tick.
  always_comb begin
    tick  = en && (pre_q == PreMax);
    pre_d = pre_q;
    if (en) begin
      pre_d = tick ? '0 : pre_q + PreW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DbW-1:0] db_q, db_d;
    logic           flip_c;

    // Debounce counter: any matching tick discards the accumulated count.
    always_comb begin
      db_d   = db_q;
      flip_c = 1'b0;
      if (tick) begin
        if (s2_q[i] == level_q[i]) begin
          db_d = '0;
        end else if (db_q == DbMax) begin
          db_d   = '0;
          flip_c = 1'b1;
        end else begin
          db_d = db_q + DbW'(1);
        end
      end
    end

    // Debounce counter register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_q <= '0;
      end else begin
        db_q <= db_d;
      end
    end

    assign flip[i] = flip_c;

    if (HOLD_TICKS > 0) begin : g_hold
      localparam int unsigned HoldW = $clog2(HOLD_TICKS + 1);
      localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_TICKS);
      localparam logic [HoldW-1:0] HoldPre = HoldW'(HOLD_TICKS - 1);

      logic [HoldW-1:0] hcnt_q, hcnt_d;
      logic             fire;

      // Hold counter: clears while low, saturates so the pulse fires once per press.
      always_comb begin
        hcnt_d = hcnt_q;
        fire   = 1'b0;
        if (!level_q[i]) begin
          hcnt_d = '0;
        end else if (tick && (hcnt_q != HoldMax)) begin
          hcnt_d = hcnt_q + HoldW'(1);
          fire   = (hcnt_q == HoldPre);
        end
      end

      // Hold counter register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hcnt_q <= '0;
        end else begin
          hcnt_q <= hcnt_d;
        end
      end

      assign hold_d[i] = fire;
    end else begin : g_no_hold
      assign hold_d[i] = 1'b0;
    end
  end

  // Level and edge pulses: a flip always moves the level to the synchronised value,
  // so the new level alone decides rise versus fall.
  always_comb begin
    level_d = level_q ^ flip;
    rise_d  = flip & s2_q;
    fall_d  = flip & ~s2_q;
  end

  // Output registers; pulses only ever last one clk since tick gates flip/fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      hold_q  <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      hold_q  <= hold_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign hold_o  = hold_q;

endmodule
